// File: rtl/sc_lifeloss_statemachine_pkg.sv
// +--------------------------------------------------------------------------+
// | sc_lifeloss_statemachine_pkg : state codes, output decode, defaults      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sc_lifeloss_statemachine_pkg;

  localparam int C_DEFAULT_MAXLIVES   = 3;
  localparam int C_DEFAULT_RESPAWNCYC = 25000000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_HIT      = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_DYING    = 3'd5,
    ST_RESPAWN  = 3'd6,
    ST_GAMEOVER = 3'd7
  } state_t;

  typedef struct packed {
    logic upcount;
    logic counterclear;
    logic freeze;
    logic respawn;
    logic gameover;
  } outs_t;

  localparam outs_t C_RST_OUTS = '{upcount: 1'b1, counterclear: 1'b1, freeze: 1'b1,
                                   respawn: 1'b0, gameover: 1'b0};

  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o = '{upcount: 1'b1, counterclear: 1'b0, freeze: 1'b0, respawn: 1'b0, gameover: 1'b0};
    case (s)
      ST_IDLE, ST_CLEAR: begin
        o.counterclear = 1'b1;
        o.freeze       = 1'b1;
      end
      ST_HIT: begin
        o.upcount = 1'b0;
        o.freeze  = 1'b1;
      end
      ST_SETTLE, ST_DYING: o.freeze = 1'b1;
      ST_RESPAWN: begin
        o.respawn = 1'b1;
        o.freeze  = 1'b1;
      end
      ST_GAMEOVER: begin
        o.gameover = 1'b1;
        o.freeze   = 1'b1;
      end
      default: o.freeze = 1'b0;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_lifeloss_statemachine_respawn_timer.sv
// +--------------------------------------------------------------------------+
// | sc_respawn_timer : loadable down-counter with zero flag                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_respawn_timer #(
  parameter int TIMERWIDTH = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [TIMERWIDTH-1:0] load_value,
  input  logic                  dec,
  output logic [TIMERWIDTH-1:0] count,
  output logic                  zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/sc_lifeloss_statemachine.sv
// +--------------------------------------------------------------------------+
// | sc_lifeloss_statemachine : death/respawn/game-over controller            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_lifeloss_statemachine
  import sc_lifeloss_statemachine_pkg::*;
#(
  parameter int LIFELOSS_DATAWIDTH  = 8,
  parameter int LIFELOSS_MAXLIVES   = C_DEFAULT_MAXLIVES,
  parameter int LIFELOSS_RESPAWNCYC = C_DEFAULT_RESPAWNCYC,
  parameter int LIFELOSS_TIMERWIDTH = 25
) (
  input  logic                          SC_LIFELOSS_CLOCK_50,
  input  logic                          SC_LIFELOSS_RESET_InLow,
  input  logic                          SC_LIFELOSS_collision_InHigh,
  input  logic                          SC_LIFELOSS_start_InLow,
  input  logic [LIFELOSS_DATAWIDTH-1:0] SC_LIFELOSS_lifecount_InBUS,
  output logic                          SC_LIFELOSS_upcount_OutLow,
  output logic                          SC_LIFELOSS_counterclear_OutHigh,
  output logic                          SC_LIFELOSS_freeze_OutHigh,
  output logic                          SC_LIFELOSS_respawn_OutHigh,
  output logic                          SC_LIFELOSS_gameover_OutHigh,
  output logic [2:0]                    SC_LIFELOSS_state_OutBUS
);

  localparam logic [LIFELOSS_DATAWIDTH-1:0]  C_MAXLIVES = LIFELOSS_DATAWIDTH'(LIFELOSS_MAXLIVES);
  localparam logic [LIFELOSS_TIMERWIDTH-1:0] C_RELOAD   = LIFELOSS_TIMERWIDTH'(LIFELOSS_RESPAWNCYC - 1);

  state_t                         state;
  state_t                         next_state;
  outs_t                          outs;
  logic                           coll_q;
  logic                           start_q;
  logic                           timer_load;
  logic                           timer_zero;
  logic [LIFELOSS_TIMERWIDTH-1:0] timer_count;

  wire coll_rise  = SC_LIFELOSS_collision_InHigh & ~coll_q;
  wire start_fall = ~SC_LIFELOSS_start_InLow & start_q;

  sc_respawn_timer #(
    .TIMERWIDTH (LIFELOSS_TIMERWIDTH)
  ) u_timer (
    .clk        (SC_LIFELOSS_CLOCK_50),
    .rst_n      (SC_LIFELOSS_RESET_InLow),
    .load       (timer_load),
    .load_value (C_RELOAD),
    .dec        (state == ST_DYING),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE:     if (start_fall) next_state = ST_CLEAR;
      ST_CLEAR:    next_state = ST_PLAY;
      ST_PLAY:     if (coll_rise) next_state = ST_HIT;
      ST_HIT:      next_state = ST_SETTLE;
      // The counter has taken the HIT pulse by now, so the bus holds the new count.
      ST_SETTLE: begin
        if (SC_LIFELOSS_lifecount_InBUS >= C_MAXLIVES) begin
          next_state = ST_GAMEOVER;
        end else begin
          next_state = ST_DYING;
          timer_load = 1'b1;
        end
      end
      ST_DYING:    if (timer_zero) next_state = ST_RESPAWN;
      ST_RESPAWN:  next_state = ST_PLAY;
      ST_GAMEOVER: if (start_fall) next_state = ST_CLEAR;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge SC_LIFELOSS_CLOCK_50 or negedge SC_LIFELOSS_RESET_InLow) begin
    if (!SC_LIFELOSS_RESET_InLow) begin
      state   <= ST_IDLE;
      outs    <= C_RST_OUTS;
      coll_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state   <= next_state;
      outs    <= decode_outs(next_state);
      coll_q  <= SC_LIFELOSS_collision_InHigh;
      start_q <= SC_LIFELOSS_start_InLow;
    end
  end

  assign SC_LIFELOSS_upcount_OutLow       = outs.upcount;
  assign SC_LIFELOSS_counterclear_OutHigh = outs.counterclear;
  assign SC_LIFELOSS_freeze_OutHigh       = outs.freeze;
  assign SC_LIFELOSS_respawn_OutHigh      = outs.respawn;
  assign SC_LIFELOSS_gameover_OutHigh     = outs.gameover;
  assign SC_LIFELOSS_state_OutBUS         = state;

endmodule

`default_nettype wire
